// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: FSM state
// encoding, shift op codes, stage distances and stage-index helpers.
package shift_pkg;

    // 3-bit state encoding, one state per shift stage plus IDLE and DONE
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S16  = 3'd1;
    localparam logic [2:0] ST_S8   = 3'd2;
    localparam logic [2:0] ST_S4   = 3'd3;
    localparam logic [2:0] ST_S2   = 3'd4;
    localparam logic [2:0] ST_S1   = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        S16  = ST_S16,
        S8   = ST_S8,
        S4   = ST_S4,
        S2   = ST_S2,
        S1   = ST_S1,
        DONE = ST_DONE
    } state_t;

    // Op codes: logical left shift and arithmetic right shift
    typedef enum logic {
        SHIFT_SLL = 1'b0,
        SHIFT_SRA = 1'b1
    } shift_op_t;

    // Fixed shift distances of the five stages
    localparam int DIST_16 = 16;
    localparam int DIST_8  = 8;
    localparam int DIST_4  = 4;
    localparam int DIST_2  = 2;
    localparam int DIST_1  = 1;

    // Stage index k selects distance 2**k and shift-amount bit k
    localparam logic [2:0] STG_16 = 3'd4;
    localparam logic [2:0] STG_8  = 3'd3;
    localparam logic [2:0] STG_4  = 3'd2;
    localparam logic [2:0] STG_2  = 3'd1;
    localparam logic [2:0] STG_1  = 3'd0;

    // Map a stage state to its stage index; non-stage states return 0
    // and are never used to update the working register.
    function automatic logic [2:0] stage_index(input state_t s);
        logic [2:0] idx;
        idx = STG_1;
        case (s)
            S16:     idx = STG_16;
            S8:      idx = STG_8;
            S4:      idx = STG_4;
            S2:      idx = STG_2;
            S1:      idx = STG_1;
            default: idx = STG_1;
        endcase
        return idx;
    endfunction

    // True while a shift stage is executing
    function automatic logic is_stage_state(input state_t s);
        return (s == S16) || (s == S8) || (s == S4) || (s == S2) || (s == S1);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle of the shift sequencer. The requester (ALU
// side) uses the master modport, the sequencer uses the slave modport.
interface shift_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);

    logic               start;
    logic [DATA_W-1:0]  data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic               ctrl_shiftop;
    logic [DATA_W-1:0]  data_result;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output start,
        output data_operandA,
        output ctrl_shiftamt,
        output ctrl_shiftop,
        input  data_result,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  start,
        input  data_operandA,
        input  ctrl_shiftamt,
        input  ctrl_shiftop,
        output data_result,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/shift_stage_mux.sv
// Combinational stage datapath: picks the fixed-distance shift of the
// working value for the current stage, either logical left (zero fill)
// or arithmetic right (sign fill).
module shift_stage_mux
    import shift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] value,
    input  logic [2:0]        stage,
    input  shift_op_t         op,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] sll16, sll8, sll4, sll2, sll1;
    logic [DATA_W-1:0] sra16, sra8, sra4, sra2, sra1;
    logic [DATA_W-1:0] selSll, selSra;

    // Fixed-distance shifters are pure wiring; only one is selected per cycle
    assign sll16 = value << DIST_16;
    assign sll8  = value << DIST_8;
    assign sll4  = value << DIST_4;
    assign sll2  = value << DIST_2;
    assign sll1  = value << DIST_1;

    assign sra16 = $signed(value) >>> DIST_16;
    assign sra8  = $signed(value) >>> DIST_8;
    assign sra4  = $signed(value) >>> DIST_4;
    assign sra2  = $signed(value) >>> DIST_2;
    assign sra1  = $signed(value) >>> DIST_1;

    // Select the shifter output belonging to the current stage, then the op
    always_comb begin
        selSll = value;
        selSra = value;
        case (stage)
            STG_16: begin
                selSll = sll16;
                selSra = sra16;
            end
            STG_8: begin
                selSll = sll8;
                selSra = sra8;
            end
            STG_4: begin
                selSll = sll4;
                selSra = sra4;
            end
            STG_2: begin
                selSll = sll2;
                selSra = sra2;
            end
            STG_1: begin
                selSll = sll1;
                selSra = sra1;
            end
            default: begin
                selSll = value;
                selSra = value;
            end
        endcase
        shifted = (op == SHIFT_SRA) ? selSra : selSll;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: walks one shift through stages of
// distance 16, 8, 4, 2, 1 (one per clock), applying a stage only when
// the matching shift-amount bit is set. Latency is fixed at six cycles
// from the start cycle to the result pulse, independent of the amount.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);

    state_t             state;
    state_t             stateNext;
    logic [DATA_W-1:0]  workReg;
    logic [DATA_W-1:0]  stageValue;
    logic [SHAMT_W-1:0] amtReg;
    shift_op_t          opReg;
    logic [2:0]         stageIdx;
    logic               stageActive;
    logic               startAccept;
    logic               applyStage;

    // A new request is taken only when no shift is in flight; starts seen
    // during the stage states are dropped without any indication.
    assign startAccept = bus.start && ((state == IDLE) || (state == DONE));
    assign stageIdx    = stage_index(state);
    assign stageActive = is_stage_state(state);
    assign applyStage  = stageActive && amtReg[stageIdx];

    shift_stage_mux #(
        .DATA_W (DATA_W)
    ) u_stage_mux (
        .value   (workReg),
        .stage   (stageIdx),
        .op      (opReg),
        .shifted (stageValue)
    );

    // State register; reset aborts any shift in flight immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: fixed stage walk, DONE can restart back-to-back
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = bus.start ? S16 : IDLE;
            S16:     stateNext = S8;
            S8:      stateNext = S4;
            S4:      stateNext = S2;
            S2:      stateNext = S1;
            S1:      stateNext = DONE;
            DONE:    stateNext = bus.start ? S16 : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Capture the amount and op of an accepted request for the stage walk
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            amtReg <= '0;
            opReg  <= SHIFT_SLL;
        end else if (startAccept) begin
            amtReg <= bus.ctrl_shiftamt;
            opReg  <= shift_op_t'(bus.ctrl_shiftop);
        end
    end

    // Working register: loads the operand on start, then takes the stage
    // result only in stages whose amount bit is set; holds otherwise so
    // the result stays stable from DONE until the next accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            workReg <= '0;
        end else if (startAccept) begin
            workReg <= bus.data_operandA;
        end else if (applyStage) begin
            workReg <= stageValue;
        end
    end

    // Output decode: busy over the five stages, result pulse in DONE
    always_comb begin
        bus.busy           = stageActive;
        bus.data_resultRDY = (state == DONE);
    end

    assign bus.data_result = workReg;

endmodule
